demosaic_mul_share_ctrl: RTL and testbench

//  Time-shares one 18x8 unsigned multiplier among NREQ demosaic requesters (R/G/B weight paths).

---
 rtl/demosaic_mul_pkg.sv | 44 ++++
 rtl/demosaic_mul_share_ctrl_if.sv | 29 ++
 rtl/demosaic_mul_pipe.sv | 79 +++++++
 rtl/demosaic_mul_share_ctrl.sv | 135 +++++++++++++
 tb/tb_demosaic_mul_share_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demosaic_mul_pkg.sv
// Shared types and helpers for the demosaic multiplier-sharing controller.
// Also holds the round-robin pick used by the request arbiter.
package demosaic_mul_pkg;

  localparam int DEF_A_WIDTH = 18;
  localparam int DEF_B_WIDTH = 8;
  localparam int DEF_P_WIDTH = 25;
  localparam int MAX_NREQ    = 8;
  localparam int MAX_ID_W    = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0]    id;
    logic [DEF_A_WIDTH-1:0] a;
    logic [DEF_B_WIDTH-1:0] b;
  } mul_req_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0]    id;
    logic [DEF_P_WIDTH-1:0] p;
  } mul_rsp_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid, searching from ptr+1 and wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int                  nreq);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      cand = (int'(ptr) + i) % nreq;
      if (i <= nreq && !res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = MAX_ID_W'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demosaic_mul_share_ctrl_if.sv
// Request/response bundle between demosaic kernels and the shared multiplier.
// Requests and responses are valid/ready: a beat transfers on a clock edge where both are high.
interface demosaic_mul_share_ctrl_if #(
  parameter int NREQ    = 3,
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = 25
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*A_WIDTH-1:0] req_a;
  logic [NREQ*B_WIDTH-1:0] req_b;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [P_WIDTH-1:0]      rsp_p;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/demosaic_mul_pipe.sv
// NUM_STAGE-deep unsigned multiplier with valid/id sideband and no back-pressure.
// Stage 0 captures operands; the truncated product travels through the remaining stages.
module demosaic_mul_pipe #(
  parameter int ID_W      = 2,
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 8,
  parameter int P_WIDTH   = 25,
  parameter int NUM_STAGE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic [ID_W-1:0]    in_id,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  output logic               out_vld,
  output logic [ID_W-1:0]    out_id,
  output logic [P_WIDTH-1:0] out_p
);
  localparam int F_WIDTH = A_WIDTH + B_WIDTH;

  logic               s0_vld;
  logic [ID_W-1:0]    s0_id;
  logic [A_WIDTH-1:0] s0_a;
  logic [B_WIDTH-1:0] s0_b;
  logic [F_WIDTH-1:0] full;
  logic [P_WIDTH-1:0] prod0;

  always_ff @(posedge clk) begin
    if (rst) s0_vld <= 1'b0;
    else     s0_vld <= in_vld;
  end

  always_ff @(posedge clk) begin
    if (in_vld) begin
      s0_id <= in_id;
      s0_a  <= in_a;
      s0_b  <= in_b;
    end
  end

  assign full  = F_WIDTH'(s0_a) * F_WIDTH'(s0_b);
  assign prod0 = P_WIDTH'(full);

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign out_vld = s0_vld;
      assign out_id  = s0_id;
      assign out_p   = prod0;
    end else begin : g_shift
      logic [NUM_STAGE-2:0] sh_vld;
      logic [ID_W-1:0]      sh_id [NUM_STAGE-1];
      logic [P_WIDTH-1:0]   sh_p  [NUM_STAGE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          sh_vld <= '0;
        end else begin
          sh_vld[0] <= s0_vld;
          for (int i = 1; i < NUM_STAGE - 1; i++) sh_vld[i] <= sh_vld[i-1];
        end
      end

      always_ff @(posedge clk) begin
        sh_id[0] <= s0_id;
        sh_p[0]  <= prod0;
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          sh_id[i] <= sh_id[i-1];
          sh_p[i]  <= sh_p[i-1];
        end
      end

      assign out_vld = sh_vld[NUM_STAGE-2];
      assign out_id  = sh_id[NUM_STAGE-2];
      assign out_p   = sh_p[NUM_STAGE-2];
    end
  endgenerate

endmodule

// File: rtl/demosaic_mul_share_ctrl.sv
// Round-robin sharing of one multiplier among NREQ requesters, with a credit-guarded
// response FIFO so that back-pressure on the response port never drops a product.
module demosaic_mul_share_ctrl
  import demosaic_mul_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int NUM_STAGE = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic ap_clk,
  input  logic ap_rst,
  demosaic_mul_share_ctrl_if.slave bus
);
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [ID_W-1:0]    rr_ptr;
  rr_pick_t           pick;
  logic               issue_ok;
  logic [NREQ-1:0]    grant;
  logic               accept;
  logic [ID_W-1:0]    gidx;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  logic [CNT_W-1:0]   credit_used;

  logic               pipe_vld;
  logic [ID_W-1:0]    pipe_id;
  logic [P_WIDTH-1:0] pipe_p;

  logic [ID_W-1:0]    mem_id [OUT_DEPTH];
  logic [P_WIDTH-1:0] mem_p  [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   mem_cnt;
  logic               out_vld;
  logic [ID_W-1:0]    out_id;
  logic [P_WIDTH-1:0] out_p;
  logic               push;
  logic               pop;
  logic               load;

  // credit_used counts every product between accept and pop, so a pop frees
  // its slot only from the following cycle.
  always_comb begin
    pick     = rr_pick(MAX_NREQ'(bus.req_valid), MAX_ID_W'(rr_ptr), NREQ);
    issue_ok = credit_used < CNT_W'(OUT_DEPTH);
    gidx     = ID_W'(pick.idx);
    grant    = '0;
    if (issue_ok && !ap_rst && pick.found) grant[gidx] = 1'b1;
    accept   = |grant;
    sel_a    = bus.req_a[gidx*A_WIDTH +: A_WIDTH];
    sel_b    = bus.req_b[gidx*B_WIDTH +: B_WIDTH];
  end

  assign bus.req_ready = grant;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr      <= ID_W'(NREQ - 1);
      credit_used <= '0;
    end else begin
      if (accept) rr_ptr <= gidx;
      credit_used <= credit_used + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  demosaic_mul_pipe #(
    .ID_W      (ID_W),
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .P_WIDTH   (P_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_pipe (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .in_vld  (accept),
    .in_id   (gidx),
    .in_a    (sel_a),
    .in_b    (sel_b),
    .out_vld (pipe_vld),
    .out_id  (pipe_id),
    .out_p   (pipe_p)
  );

  // Fall-through FIFO: storage array plus a head register that drives rsp_*.
  assign push = pipe_vld;
  assign pop  = out_vld && bus.rsp_ready;
  assign load = (mem_cnt != '0) && (!out_vld || pop);

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_id[wr_ptr] <= pipe_id;
      mem_p[wr_ptr]  <= pipe_p;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      out_id  <= '0;
      out_p   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        out_vld <= 1'b1;
        out_id  <= mem_id[rd_ptr];
        out_p   <= mem_p[rd_ptr];
      end else if (pop) begin
        out_vld <= 1'b0;
      end
      mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(load);
    end
  end

  assign bus.rsp_valid = out_vld;
  assign bus.rsp_id    = out_id;
  assign bus.rsp_p     = out_p;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      assert ($onehot0(grant));
      assert (!(push && mem_cnt == CNT_W'(OUT_DEPTH)));
    end
  end

endmodule

// File: tb/tb_demosaic_mul_share_ctrl.sv
// Scoreboard bench for demosaic_mul_share_ctrl: directed scenarios plus a randomized phase,
// checked against a round-robin/credit reference model and an expected-response queue.
module tb_demosaic_mul_share_ctrl;
  localparam int NREQ = 3;
  localparam int AW   = 18;
  localparam int BW   = 8;
  localparam int PW   = 25;
  localparam int NS   = 2;
  localparam int OD   = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + PW;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  demosaic_mul_share_ctrl_if #(.NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

  demosaic_mul_share_ctrl #(
    .NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .NUM_STAGE(NS), .OUT_DEPTH(OD)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  logic [AW-1:0]   a_v [NREQ];
  logic [BW-1:0]   b_v [NREQ];
  logic [NREQ-1:0] vld_v;
  logic [NREQ-1:0] acc_mask = '0;
  int              accept_cnt = 0;
  int              model_last = NREQ - 1;
  int              model_out = 0;
  logic            rst_edge = 1'b1;

  logic            prev_v = 1'b0;
  logic            prev_r = 1'b0;
  logic [IDW-1:0]  prev_id;
  logic [PW-1:0]   prev_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return PW'(full % (64'd1 << PW));
  endfunction

  // Plain round-robin over requester numbers, gated by outstanding-product count.
  function automatic logic [NREQ-1:0] ref_grant(input logic [NREQ-1:0] v, input int last,
                                                input int outstanding);
    logic [NREQ-1:0] r;
    int c;
    r = '0;
    if (outstanding < OD) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (last + k) % NREQ;
        if (v[c] && r == '0) r[c] = 1'b1;
      end
    end
    return r;
  endfunction

  // ---------------- clock/reset bookkeeping ----------------
  always @(posedge ap_clk) rst_edge <= ap_rst;

  // ---------------- monitor / scoreboard ----------------
  logic [NREQ-1:0] eg;
  logic [W-1:0]    e;
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      exp_q.delete();
      model_last = NREQ - 1;
      model_out  = 0;
      acc_mask   = '0;
      prev_v     = 1'b0;
    end else begin
      if (rst_edge) begin
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_p", 64'(bus.rsp_p), 64'd0);
      end else if (prev_v && !prev_r) begin
        check("hold_valid", 64'(bus.rsp_valid), 64'd1);
        check("hold_id", 64'(bus.rsp_id), 64'(prev_id));
        check("hold_p", 64'(bus.rsp_p), 64'(prev_p));
      end
      eg = ref_grant(bus.req_valid, model_last, model_out);
      check("req_ready", 64'(bus.req_ready), 64'(eg));
      acc_mask = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          exp_q.push_back({IDW'(i), ref_prod(a_v[i], b_v[i])});
          model_last = i;
          model_out++;
          accept_cnt++;
        end
      end
      if (bus.rsp_valid && exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d p=0x%0h, expected no response",
                 bus.rsp_id, bus.rsp_p);
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        e = exp_q.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(e[PW +: IDW]));
        check("rsp_p", 64'(bus.rsp_p), 64'(e[PW-1:0]));
        model_out--;
      end
      prev_v  = bus.rsp_valid;
      prev_r  = bus.rsp_ready;
      prev_id = bus.rsp_id;
      prev_p  = bus.rsp_p;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply();
    bus.req_valid = vld_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*AW +: AW] = a_v[i];
      bus.req_b[i*BW +: BW] = b_v[i];
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    a_v[i] = AW'($urandom_range(0, (1 << AW) - 1));
    b_v[i] = BW'($urandom_range(0, (1 << BW) - 1));
  endtask

  // Accepted requesters get fresh operands; waiting ones hold theirs.
  task automatic refresh_accepted();
    for (int i = 0; i < NREQ; i++) if (acc_mask[i]) rand_ops(i);
    apply();
  endtask

  task automatic wait_accept(input int i, input string name);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      step();
      if (acc_mask[i]) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no accept for requester %0d, expected one within 30 cycles", name, i);
    end
  endtask

  task automatic drain(input string name);
    vld_v = '0;
    bus.rsp_ready = 1'b1;
    apply();
    for (int t = 0; t < 60; t++) begin
      step();
      if (exp_q.size() == 0 && !bus.rsp_valid) break;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int base;
  initial begin
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    vld_v = '0;
    bus.rsp_ready = 1'b1;
    ap_rst = 1'b1;
    apply();
    repeat (3) step();
    ap_rst = 1'b0;
    step();

    // Single request from requester 1, idle design.
    a_v[1] = 18'h00012;
    b_v[1] = 8'h0A;
    vld_v  = 3'b010;
    apply();
    @(negedge ap_clk);
    check("t1_ready", 64'(bus.req_ready), 64'b010);
    step();
    vld_v = '0;
    apply();
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge ap_clk);
      if (bus.rsp_valid) begin
        lat = t;
        break;
      end
    end
    check("t1_latency", 64'(lat), 64'd3);
    drain("t1_drain");

    // Truncation corner.
    a_v[0] = 18'h3FFFF;
    b_v[0] = 8'hFF;
    vld_v  = 3'b001;
    apply();
    wait_accept(0, "t2_accept");
    vld_v = '0;
    apply();
    drain("t2_drain");

    // All requesters streaming, consumer always ready.
    vld_v = '1;
    apply();
    repeat (24) begin
      step();
      refresh_accepted();
    end
    drain("t3_drain");

    // Consumer stalled: only OUT_DEPTH accepts fit.
    base = accept_cnt;
    bus.rsp_ready = 1'b0;
    vld_v = '1;
    apply();
    repeat (12) begin
      step();
      refresh_accepted();
    end
    check("t4_stall_accepts", 64'(accept_cnt - base), 64'(OD));
    bus.rsp_ready = 1'b1;
    repeat (12) begin
      step();
      refresh_accepted();
    end
    drain("t4_drain");

    // Requesters 0 and 2 only, starting after a grant to 0; then 2 drops out.
    vld_v = 3'b001;
    apply();
    wait_accept(0, "t5_seed");
    vld_v = 3'b101;
    refresh_accepted();
    repeat (10) begin
      step();
      refresh_accepted();
    end
    vld_v = 3'b001;
    apply();
    repeat (10) begin
      step();
      refresh_accepted();
    end
    drain("t5_drain");

    // Reset with two products in the FIFO and two in the pipeline.
    base = accept_cnt;
    bus.rsp_ready = 1'b0;
    vld_v = '1;
    apply();
    for (int t = 0; t < 20; t++) begin
      step();
      refresh_accepted();
      if (accept_cnt - base >= OD) break;
    end
    check("t6_preload", 64'(accept_cnt - base), 64'(OD));
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    bus.rsp_ready = 1'b1;
    vld_v = '0;
    apply();
    repeat (6) step();
    vld_v = '1;
    apply();
    @(negedge ap_clk);
    check("t6_first_grant", 64'(bus.req_ready), 64'b001);
    repeat (6) begin
      step();
      refresh_accepted();
    end
    drain("t6_drain");

    // Randomized traffic with random back-pressure and one reset.
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c == 700) ap_rst = 1'b1;
      if (c == 702) ap_rst = 1'b0;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(vld_v[i] && !acc_mask[i])) begin
          vld_v[i] = 1'($urandom_range(0, 1));
          rand_ops(i);
        end
      end
      apply();
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
